dist_tx_sched: RTL and testbench

DIST_TX_SCHED -- requirements
Module: dist_tx_sched

---
 rtl/dist_tx_sched.sv | 211 +++++++++++++++++++++
 tb/tb_dist_tx_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_tx_sched.sv
// -----------------------------------------------------------------------------
// dist_tx_sched -- distance-point transmit scheduler
//
// Buffers resampled distance points in an 8-entry FIFO. Each point is sent
// downstream as three 16-bit words: angle, dist, rssi. Revolution headers
// (A55A + frame count) and requested status words are merged into the same
// valid/ready stream. A fixed-priority arbiter picks the next source only at
// a word-group boundary, so a point's three words always stay together.
//
// Optional feature: define DIST_CHKSUM_EN to add a 16-bit wrapping checksum
// of all transferred point words. The checksum is sent as one word just
// before each header, and the sum restarts from zero after it is sent.
//
// Ports
//   i_clk_50m    single system clock
//   i_rst_n      asynchronous active-low reset
//   i_zero_sign  revolution-start pulse (queues at most one header)
//   i_dist_sig   point-valid strobe; samples i_code_angle / i_edge_data
//   i_code_angle point angle
//   i_edge_data  {rise, fall, dist, rssi}; only dist[31:16] and rssi[15:0]
//                are used
//   i_stat_req   status request, held high until o_stat_ack
//   i_stat_data  status word, captured when the status word is selected
//   o_stat_ack   one-cycle pulse when the status word transfers
//   o_tx_valid   word offered downstream
//   o_tx_data    offered word, held stable while stalled
//   i_tx_ready   downstream accepts the word
//   o_ovf_cnt    dropped-point count, saturates at 255
//   o_frame_cnt  emitted-header count, wraps
// -----------------------------------------------------------------------------
module dist_tx_sched (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_zero_sign,
  input  logic        i_dist_sig,
  input  logic [15:0] i_code_angle,
  input  logic [63:0] i_edge_data,
  input  logic        i_stat_req,
  input  logic [15:0] i_stat_data,
  output logic        o_stat_ack,
  output logic        o_tx_valid,
  output logic [15:0] o_tx_data,
  input  logic        i_tx_ready,
  output logic [7:0]  o_ovf_cnt,
  output logic [15:0] o_frame_cnt
);

  localparam int DEPTH = 8;
  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_STAT, S_PANG, S_PDST, S_PRSI
`ifdef DIST_CHKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] mem_q [DEPTH];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic [47:0] pt_q, pt_d;
  logic [15:0] stat_q, stat_d;
  logic        hdr_pend_q, hdr_pend_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [15:0] frame_q, frame_d;
`ifdef DIST_CHKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic pop;
  logic push;
  logic full;
  logic hdr1_done;
  logic unused_edge;

  // rise/fall halves of the edge word are not carried in the point.
  assign unused_edge = ^i_edge_data[63:32];

  // ---------------------------------------------------------------------------
  // Arbitration and word sequencing
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    pt_d    = pt_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE: begin
        if (hdr_pend_q) begin
`ifdef DIST_CHKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_HDR0;
`endif
        end else if (i_stat_req) begin
          state_d = S_STAT;
          stat_d  = i_stat_data;
        end else if (count_q != 4'd0) begin
          // The point leaves the FIFO here, so its slot is free for a
          // write arriving in this same cycle.
          state_d = S_PANG;
          pop     = 1'b1;
          pt_d    = mem_q[rd_ptr_q];
        end
      end
`ifdef DIST_CHKSUM_EN
      S_CSUM: if (i_tx_ready) state_d = S_HDR0;
`endif
      S_HDR0: if (i_tx_ready) state_d = S_HDR1;
      S_HDR1: if (i_tx_ready) state_d = S_IDLE;
      S_STAT: if (i_tx_ready) state_d = S_IDLE;
      S_PANG: if (i_tx_ready) state_d = S_PDST;
      S_PDST: if (i_tx_ready) state_d = S_PRSI;
      S_PRSI: if (i_tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output word is a pure function of registered state, so it cannot change
  // while a word is stalled.
  always_comb begin
    o_tx_data = 16'h0000;
    unique case (state_q)
`ifdef DIST_CHKSUM_EN
      S_CSUM: o_tx_data = csum_q;
`endif
      S_HDR0: o_tx_data = HDR_MAGIC;
      S_HDR1: o_tx_data = frame_q;
      S_STAT: o_tx_data = stat_q;
      S_PANG: o_tx_data = pt_q[47:32];
      S_PDST: o_tx_data = pt_q[31:16];
      S_PRSI: o_tx_data = pt_q[15:0];
      default: o_tx_data = 16'h0000;
    endcase
  end

  assign o_tx_valid  = (state_q != S_IDLE);
  assign o_stat_ack  = (state_q == S_STAT) & i_tx_ready;
  assign o_ovf_cnt   = ovf_q;
  assign o_frame_cnt = frame_q;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping, header flag, counters
  // ---------------------------------------------------------------------------
  always_comb begin
    full      = (count_q == 4'(DEPTH));
    push      = i_dist_sig & (~full | pop);
    wr_ptr_d  = wr_ptr_q + 3'(push);
    rd_ptr_d  = rd_ptr_q + 3'(pop);
    count_d   = count_q + 4'(push) - 4'(pop);
    ovf_d     = ovf_q;
    if (i_dist_sig && !push && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    hdr1_done = (state_q == S_HDR1) & i_tx_ready;
    // A pulse while a header is already pending (including its final
    // transfer cycle) is absorbed into that header.
    hdr_pend_d = hdr_pend_q ? ~hdr1_done : i_zero_sign;
    frame_d    = frame_q + 16'(hdr1_done);
`ifdef DIST_CHKSUM_EN
    csum_d = csum_q;
    if (state_q == S_CSUM && i_tx_ready) begin
      csum_d = 16'h0000;
    end else if ((state_q == S_PANG || state_q == S_PDST || state_q == S_PRSI)
                 && i_tx_ready) begin
      csum_d = csum_q + o_tx_data;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pt_q       <= '0;
      stat_q     <= '0;
      hdr_pend_q <= 1'b0;
      ovf_q      <= '0;
      frame_q    <= '0;
`ifdef DIST_CHKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pt_q       <= pt_d;
      stat_q     <= stat_d;
      hdr_pend_q <= hdr_pend_d;
      ovf_q      <= ovf_d;
      frame_q    <= frame_d;
`ifdef DIST_CHKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // and count empties the FIFO, and stale entries are never read.
  always_ff @(posedge i_clk_50m) begin
    if (push) mem_q[wr_ptr_q] <= {i_code_angle, i_edge_data[31:0]};
  end

endmodule

// File: tb/tb_dist_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_dist_tx_sched -- self-checking bench for dist_tx_sched
//
// A word-queue model predicts the output stream: when nothing is queued for
// output it picks the next group (header, status, or point) by priority and
// appends its words; each accepted word is removed and logged. Directed
// scenarios then compare the logged stream with hand-written word lists,
// followed by a randomized run checked cycle by cycle against the model.
// -----------------------------------------------------------------------------
module tb_dist_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zero_sign = 1'b0;
  logic        dist_sig = 1'b0;
  logic [15:0] code_angle = '0;
  logic [63:0] edge_data = '0;
  logic        stat_req = 1'b0;
  logic [15:0] stat_data = '0;
  logic        tx_ready = 1'b0;
  logic        stat_ack;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic [7:0]  ovf_cnt;
  logic [15:0] frame_cnt;

  always #10 clk = ~clk;

  dist_tx_sched dut (
    .i_clk_50m   (clk),
    .i_rst_n     (rst_n),
    .i_zero_sign (zero_sign),
    .i_dist_sig  (dist_sig),
    .i_code_angle(code_angle),
    .i_edge_data (edge_data),
    .i_stat_req  (stat_req),
    .i_stat_data (stat_data),
    .o_stat_ack  (stat_ack),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .i_tx_ready  (tx_ready),
    .o_ovf_cnt   (ovf_cnt),
    .o_frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {W_PT, W_STAT, W_HDR0, W_HDR1, W_CSUM} wtag_t;

  logic [47:0] m_fifo[$];
  logic [15:0] m_word[$];
  wtag_t       m_tag[$];
  bit          m_hdr;
  logic [15:0] m_frame;
  logic [7:0]  m_ovf;
  logic [15:0] m_sum;

  logic [15:0] got[$];
  int          got_cyc[$];
  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          ack_cnt = 0;
  bit          ack_seen = 1'b0;

  // One clock cycle of the model, evaluated mid-cycle with inputs stable.
  task automatic model_step();
    bit          exp_v;
    bit          hdr_clr;
    logic [47:0] p;
    logic [15:0] w;
    wtag_t       t;
    cyc++;
    ack_seen = stat_ack;
    if (stat_ack) ack_cnt++;
    if (!rst_n) begin
      m_fifo.delete(); m_word.delete(); m_tag.delete();
      m_hdr = 1'b0; m_frame = '0; m_ovf = '0; m_sum = '0;
      check("reset_valid", tx_valid, 0);
      check("reset_data", tx_data, 0);
      check("reset_ack", stat_ack, 0);
      check("reset_ovf", ovf_cnt, 0);
      check("reset_frame", frame_cnt, 0);
    end else begin
      exp_v   = (m_word.size() != 0);
      hdr_clr = 1'b0;
      check("tx_valid", tx_valid, exp_v);
      if (exp_v) check("tx_data", tx_data, m_word[0]);
      check("stat_ack", stat_ack, exp_v && m_tag[0] == W_STAT && tx_ready);
      check("ovf_cnt", ovf_cnt, m_ovf);
      check("frame_cnt", frame_cnt, m_frame);
      if (!exp_v) begin
        if (m_hdr) begin
`ifdef DIST_CHKSUM_EN
          m_word.push_back(m_sum); m_tag.push_back(W_CSUM);
`endif
          m_word.push_back(16'hA55A);  m_tag.push_back(W_HDR0);
          m_word.push_back(m_frame);   m_tag.push_back(W_HDR1);
        end else if (stat_req) begin
          m_word.push_back(stat_data); m_tag.push_back(W_STAT);
        end else if (m_fifo.size() > 0) begin
          p = m_fifo.pop_front();
          m_word.push_back(p[47:32]); m_tag.push_back(W_PT);
          m_word.push_back(p[31:16]); m_tag.push_back(W_PT);
          m_word.push_back(p[15:0]);  m_tag.push_back(W_PT);
        end
      end else if (tx_ready) begin
        w = m_word.pop_front();
        t = m_tag.pop_front();
        got.push_back(w);
        got_cyc.push_back(cyc);
        case (t)
          W_PT:   m_sum = m_sum + w;
          W_CSUM: m_sum = '0;
          W_HDR1: begin m_frame = m_frame + 16'd1; hdr_clr = 1'b1; end
          default: ;
        endcase
      end
      if (dist_sig) begin
        if (m_fifo.size() < 8) m_fifo.push_back({code_angle, edge_data[31:0]});
        else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
      end
      m_hdr = m_hdr ? !hdr_clr : zero_sign;
    end
  endtask

  // Compare mid-cycle, then move to just after the next rising edge where
  // stimulus is applied. Strobes are one-cycle; status request drops after ack.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    zero_sign = 1'b0;
    dist_sig  = 1'b0;
    if (ack_seen) stat_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_point(input logic [15:0] a, input logic [15:0] d, input logic [15:0] r);
    dist_sig   = 1'b1;
    code_angle = a;
    edge_data  = {$urandom(), d, r};
    tick();
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got.size() < n) check("timeout_words", got.size(), n);
  endtask

  task automatic expect_words(input string name);
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int strobe_cyc;
    int ack0;

    // Reset state
    idle(3);
    check("lit_reset_valid", tx_valid, 0);
    check("lit_reset_frame", frame_cnt, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    idle(2);

    // Single point: three consecutive words, two cycles after the strobe
    clear_log();
    send_point(16'h0010, 16'h1234, 16'h0056);
    strobe_cyc = cyc;
    wait_got(3, 20);
    exp_q = '{16'h0010, 16'h1234, 16'h0056};
    expect_words("single");
    if (got_cyc.size() >= 3) begin
      check("single_consecutive", got_cyc[2] - got_cyc[0], 2);
      check("single_latency", got_cyc[0] - strobe_cyc, 2);
    end

`ifndef DIST_CHKSUM_EN
    // Revolution start with frame count at 5
    repeat (5) begin
      clear_log();
      zero_sign = 1'b1;
      tick();
      wait_got(2, 20);
    end
    idle(2);
    check("lit_frame5", frame_cnt, 5);
    clear_log();
    zero_sign = 1'b1;
    tick();
    zero_sign = 1'b1;            // second pulse while pending: no extra header
    send_point(16'h0020, 16'h0BAD, 16'h0077);
    wait_got(5, 30);
    idle(4);
    exp_q = '{16'hA55A, 16'h0005, 16'h0020, 16'h0BAD, 16'h0077};
    expect_words("rev");
    check("lit_frame6", frame_cnt, 6);
`endif

    // Status request raised mid-point waits for the group to finish
    clear_log();
    send_point(16'h0100, 16'h0200, 16'h0300);
    send_point(16'h0101, 16'h0201, 16'h0301);
    wait_got(1, 20);
    check("arb_in_pdst_data", tx_data, 16'h0200);
    stat_req  = 1'b1;
    stat_data = 16'hBEEF;
    ack0 = ack_cnt;
    wait_got(7, 40);
    idle(2);
    exp_q = '{16'h0100, 16'h0200, 16'h0300, 16'hBEEF, 16'h0101, 16'h0201, 16'h0301};
    expect_words("arb");
    check("arb_ack_pulses", ack_cnt - ack0, 1);

`ifndef DIST_CHKSUM_EN
    // Overflow: scheduler parked on a header, 10 strobes into 8 slots
    clear_log();
    tx_ready = 1'b0;
    zero_sign = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++)
      send_point(16'(i), 16'(16'h1000 + i), 16'(16'h2000 + i));
    check("lit_ovf2", ovf_cnt, 2);
    tx_ready = 1'b1;
    wait_got(26, 100);
    exp_q = '{16'hA55A, 16'h0006};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(i));
      exp_q.push_back(16'(16'h1000 + i));
      exp_q.push_back(16'(16'h2000 + i));
    end
    expect_words("ovf");
`endif

    // Backpressure: ready toggles every cycle
    clear_log();
    send_point(16'h0A01, 16'h0B01, 16'h0C01);
    send_point(16'h0A02, 16'h0B02, 16'h0C02);
    send_point(16'h0A03, 16'h0B03, 16'h0C03);
    for (int i = 0; i < 30; i++) begin
      tx_ready = ~tx_ready;
      tick();
    end
    tx_ready = 1'b1;
    wait_got(9, 40);
    exp_q = '{16'h0A01, 16'h0B01, 16'h0C01, 16'h0A02, 16'h0B02, 16'h0C02,
              16'h0A03, 16'h0B03, 16'h0C03};
    expect_words("bp");

    // Reset in PDST: group discarded, queued point flushed
    clear_log();
    send_point(16'h0E01, 16'h0E02, 16'h0E03);
    send_point(16'h0F01, 16'h0F02, 16'h0F03);
    wait_got(1, 20);
    rst_n = 1'b0;
    tick();
    check("lit_rst_mid_valid", tx_valid, 0);
    rst_n = 1'b1;
    clear_log();
    idle(10);
    check("rst_flush_words", got.size(), 0);
    check("lit_rst_frame", frame_cnt, 0);

`ifndef DIST_CHKSUM_EN
    // Overflow counter saturates
    clear_log();
    tx_ready = 1'b0;
    zero_sign = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 300; i++) send_point(16'($urandom), 16'($urandom), 16'($urandom));
    check("lit_ovf_sat", ovf_cnt, 255);
    tx_ready = 1'b1;
    wait_got(26, 200);
`endif

`ifdef DIST_CHKSUM_EN
    // Checksum word precedes the header
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    send_point(16'd1, 16'd2, 16'd3);
    send_point(16'd4, 16'd5, 16'd6);
    wait_got(6, 30);
    zero_sign = 1'b1;
    tick();
    wait_got(9, 30);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'h0015, 16'hA55A, 16'h0000};
    expect_words("csum");
`endif

    // Randomized traffic against the model
    clear_log();
    for (int i = 0; i < 3000; i++) begin
      tx_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        dist_sig   = 1'b1;
        code_angle = 16'($urandom);
        edge_data  = {$urandom(), $urandom()};
      end
      if ($urandom_range(0, 99) == 0) zero_sign = 1'b1;
      if (!stat_req && $urandom_range(0, 59) == 0) begin
        stat_req  = 1'b1;
        stat_data = 16'($urandom);
      end
      tick();
    end
    tx_ready = 1'b1;
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
